// File: rtl/alu_pkg.sv
// Shared types and helpers for the 3BC execute stage: opcode and FSM state
// encodings plus the single-cycle/iterative classification.
package alu_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 2;
    localparam int CW_DEF = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_MULH = 3'b111
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shifts by zero complete in one edge; every multiply iterates.
    function automatic logic is_iterative(input op_t op, input logic [2:0] shamt);
        logic iter;
        case (op)
            OP_SHL, OP_SHR:  iter = (shamt != 3'd0);
            OP_MUL, OP_MULH: iter = 1'b1;
            default:         iter = 1'b0;
        endcase
        return iter;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback bundle between control, register file and the execute stage.
interface alu_seq_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          Start;
    logic [2:0]    Op;
    logic [DW-1:0] InA;
    logic [DW-1:0] InB;
    logic [AW-1:0] DestIn;
    logic          Busy;
    logic          Done;
    logic [DW-1:0] Result;
    logic          WriteEn;
    logic [AW-1:0] Waddr;
    logic          Carry;
    logic          Zero;

    modport master (
        output Start, Op, InA, InB, DestIn,
        input  Busy, Done, Result, WriteEn, Waddr, Carry, Zero
    );

    modport slave (
        input  Start, Op, InA, InB, DestIn,
        output Busy, Done, Result, WriteEn, Waddr, Carry, Zero
    );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle datapath: ADD/SUB/AND/XOR and zero-distance shifts with flag.
module alu_comb
    import alu_pkg::*;
#(
    parameter int DW = 8
) (
    input  op_t           op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] res_o,
    output logic          carry_o
);
    logic [DW:0] sum_s;
    logic [DW:0] diff_s;

    assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
    // Bit DW of the widened difference is the borrow (a < b).
    assign diff_s = {1'b0, a_i} - {1'b0, b_i};

    // Result/flag select; shifts reaching here have distance 0 and pass A.
    always_comb begin
        res_o   = a_i;
        carry_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_o   = sum_s[DW-1:0];
                carry_o = sum_s[DW];
            end
            OP_SUB: begin
                res_o   = diff_s[DW-1:0];
                carry_o = diff_s[DW];
            end
            OP_AND: begin
                res_o   = a_i & b_i;
                carry_o = 1'b0;
            end
            OP_XOR: begin
                res_o   = a_i ^ b_i;
                carry_o = 1'b0;
            end
            default: begin
                res_o   = a_i;
                carry_o = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// Execute stage: single-cycle ops via alu_comb, bit-serial shifts and
// shift-add multiply in RUN, and register-file writeback on Done.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic     Clk,
    input  logic     Reset,
    alu_seq_if.slave bus
);
    state_t          state_q;
    logic            busy_q, done_q, carry_q, zero_q;
    logic [DW-1:0]   result_q;
    logic [AW-1:0]   waddr_q, dest_q;
    op_t             op_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   sh_q, mplier_q;
    logic [2*DW-1:0] prod_q, mcand_q;

    op_t             op_in_s;
    logic [DW-1:0]   comb_res_s;
    logic            comb_carry_s;
    logic [2*DW-1:0] prod_d;
    logic [DW-1:0]   sh_d, fin_res_d;
    logic            shout_d, fin_carry_d;

    assign op_in_s = op_t'(bus.Op);

    alu_comb #(.DW(DW)) u_comb (
        .op_i    (op_in_s),
        .a_i     (bus.InA),
        .b_i     (bus.InB),
        .res_o   (comb_res_s),
        .carry_o (comb_carry_s)
    );

    // One iteration step and the value that completes the latched op.
    always_comb begin
        prod_d  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        sh_d    = (op_q == OP_SHL) ? {sh_q[DW-2:0], 1'b0} : {1'b0, sh_q[DW-1:1]};
        shout_d = (op_q == OP_SHL) ? sh_q[DW-1] : sh_q[0];
        case (op_q)
            OP_MUL: begin
                fin_res_d   = prod_d[DW-1:0];
                fin_carry_d = |prod_d[2*DW-1:DW];
            end
            OP_MULH: begin
                fin_res_d   = prod_d[2*DW-1:DW];
                fin_carry_d = |prod_d[2*DW-1:DW];
            end
            default: begin
                fin_res_d   = sh_d;
                fin_carry_d = shout_d;
            end
        endcase
    end

    // FSM, iteration state and registered writeback outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= {DW{1'b0}};
            waddr_q  <= {AW{1'b0}};
            dest_q   <= {AW{1'b0}};
            op_q     <= OP_ADD;
            cnt_q    <= {CW{1'b0}};
            sh_q     <= {DW{1'b0}};
            mplier_q <= {DW{1'b0}};
            prod_q   <= {(2*DW){1'b0}};
            mcand_q  <= {(2*DW){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Start && !is_iterative(op_in_s, bus.InB[2:0])) begin
                        done_q   <= 1'b1;
                        result_q <= comb_res_s;
                        carry_q  <= comb_carry_s;
                        zero_q   <= (comb_res_s == {DW{1'b0}});
                        waddr_q  <= bus.DestIn;
                    end else if (bus.Start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        op_q     <= op_in_s;
                        dest_q   <= bus.DestIn;
                        sh_q     <= bus.InA;
                        prod_q   <= {(2*DW){1'b0}};
                        mcand_q  <= {{DW{1'b0}}, bus.InA};
                        mplier_q <= bus.InB;
                        cnt_q    <= (op_in_s == OP_MUL || op_in_s == OP_MULH)
                                    ? CW'(DW) : CW'(bus.InB[2:0]);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    cnt_q    <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    sh_q     <= sh_d;
                    prod_q   <= prod_d;
                    mcand_q  <= {mcand_q[2*DW-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[DW-1:1]};
                    if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= fin_res_d;
                        carry_q  <= fin_carry_d;
                        zero_q   <= (fin_res_d == {DW{1'b0}});
                        waddr_q  <= dest_q;
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.WriteEn = done_q;
    assign bus.Result  = result_q;
    assign bus.Carry   = carry_q;
    assign bus.Zero    = zero_q;
    assign bus.Waddr   = waddr_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: issue driver pushes reference results,
// a negedge monitor pops and compares on every WriteEn pulse.
module tb_alu_seq;
    logic Clk;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic [1:0] w;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] rf [4];

    alu_seq_if #(.DW(8), .AW(2)) bus ();

    alu_seq dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Small register file fed by the writeback port
    initial for (int i = 0; i < 4; i++) rf[i] = 8'd0;
    always @(posedge Clk) if (bus.WriteEn) rf[bus.Waddr] <= bus.Result;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from plain arithmetic on the opcode definitions.
    task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output int lat);
        int ia = a, ib = b, n = b[2:0], s;
        lat = 1;
        case (op)
            3'd0: begin s = ia + ib; r = 8'(s); c = (s > 255); end
            3'd1: begin s = ia - ib; r = 8'(s); c = (ia < ib); end
            3'd2: begin r = a & b; c = 1'b0; end
            3'd3: begin r = a ^ b; c = 1'b0; end
            3'd4: begin r = 8'(ia << n); c = (n == 0) ? 1'b0 : 1'((ia >> (8 - n)) & 1);
                        lat = n + 1; end
            3'd5: begin r = 8'(ia >> n); c = (n == 0) ? 1'b0 : 1'((ia >> (n - 1)) & 1);
                        lat = n + 1; end
            3'd6: begin s = ia * ib; r = 8'(s); c = (s > 255); lat = 9; end
            default: begin s = ia * ib; r = 8'(s >> 8); c = (s > 255); lat = 9; end
        endcase
    endtask

    // Issue one op; while busy, throw ignored Start pulses with junk operands.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] d);
        exp_t e; logic [7:0] r; logic c; int lat;
        model(op, a, b, r, c, lat);
        bus.Start = 1'b1; bus.Op = op; bus.InA = a; bus.InB = b; bus.DestIn = d;
        @(posedge Clk); #1;
        e.res = r; e.c = c; e.z = (r == 8'd0); e.w = d; e.cyc = cyc + lat - 1;
        sbq.push_back(e);
        for (int i = 1; i < lat; i++) begin
            chk("busy_run", int'(bus.Busy), 1);
            bus.Start = 1'($urandom_range(0, 1)); bus.Op = 3'($urandom);
            bus.InA = 8'($urandom); bus.InB = 8'($urandom); bus.DestIn = 2'($urandom);
            @(posedge Clk); #1;
        end
        chk("busy_idle", int'(bus.Busy), 0);
        bus.Start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    // Monitor: every writeback must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("we_eq_done", int'(bus.WriteEn), int'(bus.Done));
            if (bus.WriteEn) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result", int'(bus.Result), int'(e.res));
                    chk("carry", int'(bus.Carry), int'(e.c));
                    chk("zero", int'(bus.Zero), int'(e.z));
                    chk("waddr", int'(bus.Waddr), int'(e.w));
                    chk("latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Start = 1'b0; bus.Op = 3'd0; bus.InA = 8'd0; bus.InB = 8'd0; bus.DestIn = 2'd0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("rst_busy", int'(bus.Busy), 0);
        chk("rst_done", int'(bus.Done), 0);
        chk("rst_result", int'(bus.Result), 0);
        chk("rst_carry", int'(bus.Carry), 0);
        chk("rst_zero", int'(bus.Zero), 0);
        chk("rst_waddr", int'(bus.Waddr), 0);

        issue(3'd0, 8'hF0, 8'h20, 2'd2);
        idle(1);
        issue(3'd1, 8'h05, 8'h05, 2'd1);
        issue(3'd1, 8'h03, 8'h05, 2'd3);
        idle(1);
        issue(3'd4, 8'b1000_0011, 8'd3, 2'd0);
        issue(3'd5, 8'h81, 8'd0, 2'd1);
        issue(3'd6, 8'd200, 8'd3, 2'd2);
        issue(3'd7, 8'd200, 8'd3, 2'd3);
        idle(2);

        // Abort a multiply with reset in its 4th RUN cycle
        bus.Start = 1'b1; bus.Op = 3'd6; bus.InA = 8'hFF; bus.InB = 8'hFF; bus.DestIn = 2'd3;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        idle(3);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("abort_busy", int'(bus.Busy), 0);
        chk("abort_done", int'(bus.Done), 0);
        chk("abort_we", int'(bus.WriteEn), 0);
        chk("abort_result", int'(bus.Result), 0);
        idle(12);
        issue(3'd0, 8'd1, 8'd1, 2'd0);
        idle(2);

        for (int k = 0; k < 40; k++) begin
            issue(3'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        // Register-file round trip: R1=7, R2=9, R3=R1*R2
        issue(3'd0, 8'd0, 8'd7, 2'd1);
        issue(3'd0, 8'd0, 8'd9, 2'd2);
        idle(1);
        issue(3'd6, rf[1], rf[2], 2'd3);
        idle(2);
        chk("rf_r3", int'(rf[3]), 63);

        for (int t = 0; t < 20 && sbq.size() != 0; t++) idle(1);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
